fft_stage_sequencer: RTL and testbench

// Sequences the in-place radix-2 decimation-in-frequency FFT over the shared

---
 rtl/fft_stage_sequencer_if.sv | 34 +++
 rtl/fft_stage_sequencer.sv | 174 +++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_stage_sequencer_if.sv
// Control/handshake bundle between the FFT stage sequencer, the data/twiddle
// RAMs, the butterfly unit and the main FSM.
interface fft_stage_sequencer_if #(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned TW_W   = 5
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_wsel;
    logic [TW_W-1:0]   tw_addr;
    logic              a_ld;
    logic              b_ld;
    logic              bf_start;
    logic              bf_done;
    logic [LOG2N-1:0]  stage;

    // Sequencer side
    modport master (
        input  start, bf_done,
        output busy, done, mem_addr, mem_we, mem_wsel, tw_addr,
               a_ld, b_ld, bf_start, stage
    );

    // Environment side (main FSM, RAMs, butterfly)
    modport slave (
        output start, bf_done,
        input  busy, done, mem_addr, mem_we, mem_wsel, tw_addr,
               a_ld, b_ld, bf_start, stage
    );
endinterface

// File: rtl/fft_stage_sequencer.sv
// In-place radix-2 DIF FFT sequencer: walks every stage and butterfly,
// generating operand/twiddle addresses and the load, start and write strobes.
module fft_stage_sequencer #(
    parameter int unsigned LOG2N  = 6,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned TW_W   = 5
) (
    input logic                 clk,
    input logic                 rst,
    fft_stage_sequencer_if.master bus
);

    localparam int unsigned      BW     = LOG2N - 1;
    localparam logic [BW-1:0]    B_LAST = {BW{1'b1}};
    localparam logic [LOG2N-1:0] S_LAST = LOG2N'(LOG2N - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD_A, ST_RD_B, ST_CAPT, ST_WAIT, ST_WR_A, ST_WR_B, ST_FIN
    } state_t;

    state_t            state, state_n;
    logic [LOG2N-1:0]  s_q, s_n;
    logic [BW-1:0]     b_q, b_n;

    logic [ADDR_W-1:0] span, mask, bx, low, idx_i, idx_j;
    logic [TW_W-1:0]   idx_tw;

    logic              busy_q, busy_n;
    logic              done_q, done_n;
    logic              we_q, we_n;
    logic              wsel_q, wsel_n;
    logic              a_ld_q, a_ld_n;
    logic              b_ld_q, b_ld_n;
    logic              bf_start_q, bf_start_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [TW_W-1:0]   tw_q, tw_n;

    // Next state and stage/butterfly counter advance
    always_comb begin
        state_n = state;
        s_n     = s_q;
        b_n     = b_q;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_RD_A;
                    s_n     = '0;
                    b_n     = '0;
                end
            end
            ST_RD_A: state_n = ST_RD_B;
            ST_RD_B: state_n = ST_CAPT;
            ST_CAPT: state_n = ST_WAIT;
            ST_WAIT: begin
                if (bus.bf_done) begin
                    state_n = ST_WR_A;
                end
            end
            ST_WR_A: state_n = ST_WR_B;
            ST_WR_B: begin
                if (b_q != B_LAST) begin
                    b_n     = b_q + BW'(1);
                    state_n = ST_RD_A;
                end else if (s_q != S_LAST) begin
                    s_n     = s_q + LOG2N'(1);
                    b_n     = '0;
                    state_n = ST_RD_A;
                end else begin
                    state_n = ST_FIN;
                end
            end
            ST_FIN:  state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand/twiddle indices for the butterfly being entered (shift/mask only)
    always_comb begin
        span   = ADDR_W'(1) << (S_LAST - s_n);
        mask   = span - ADDR_W'(1);
        bx     = ADDR_W'(b_n);
        low    = bx & mask;
        idx_i  = ((bx & ~mask) << 1) | low;
        idx_j  = idx_i | span;
        idx_tw = TW_W'(low << s_n);
    end

    // Output values for the state being entered, so the registered strobes line up with it
    always_comb begin
        busy_n     = 1'b0;
        done_n     = 1'b0;
        we_n       = 1'b0;
        wsel_n     = 1'b0;
        a_ld_n     = 1'b0;
        b_ld_n     = 1'b0;
        bf_start_n = 1'b0;
        addr_n     = addr_q;
        tw_n       = tw_q;
        case (state_n)
            ST_RD_A: begin
                busy_n = 1'b1;
                addr_n = idx_i;
                tw_n   = idx_tw;
            end
            ST_RD_B: begin
                busy_n = 1'b1;
                addr_n = idx_j;
                a_ld_n = 1'b1;
            end
            ST_CAPT: begin
                busy_n     = 1'b1;
                b_ld_n     = 1'b1;
                bf_start_n = 1'b1;
            end
            ST_WAIT: busy_n = 1'b1;
            ST_WR_A: begin
                busy_n = 1'b1;
                addr_n = idx_i;
                we_n   = 1'b1;
            end
            ST_WR_B: begin
                busy_n = 1'b1;
                addr_n = idx_j;
                we_n   = 1'b1;
                wsel_n = 1'b1;
            end
            ST_FIN:  done_n = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered outputs; reset aborts with no further writes
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            s_q        <= '0;
            b_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_q       <= 1'b0;
            wsel_q     <= 1'b0;
            a_ld_q     <= 1'b0;
            b_ld_q     <= 1'b0;
            bf_start_q <= 1'b0;
            addr_q     <= '0;
            tw_q       <= '0;
        end else begin
            state      <= state_n;
            s_q        <= s_n;
            b_q        <= b_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
            we_q       <= we_n;
            wsel_q     <= wsel_n;
            a_ld_q     <= a_ld_n;
            b_ld_q     <= b_ld_n;
            bf_start_q <= bf_start_n;
            addr_q     <= addr_n;
            tw_q       <= tw_n;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_we   = we_q;
    assign bus.mem_wsel = wsel_q;
    assign bus.tw_addr  = tw_q;
    assign bus.a_ld     = a_ld_q;
    assign bus.b_ld     = b_ld_q;
    assign bus.bf_start = bf_start_q;
    assign bus.stage    = s_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: an 8-point instance with RAM/butterfly
// models for the address table and data checks, and a 64-point instance for
// timing, wait handling and mid-run reset.
module tb_fft_stage_sequencer;

    typedef struct {
        int s;
        int i;
        int j;
        int tw;
    } vec_t;

    logic clk;
    logic rst_s;
    logic rst_l;
    int   n_cmp = 0;
    int   n_err = 0;
    int   dly_l = 0;

    fft_stage_sequencer_if #(.LOG2N(3), .ADDR_W(3), .TW_W(2)) bs ();
    fft_stage_sequencer_if #(.LOG2N(6), .ADDR_W(6), .TW_W(5)) bl ();

    fft_stage_sequencer #(.LOG2N(3), .ADDR_W(3), .TW_W(2)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (bs.master)
    );

    fft_stage_sequencer #(.LOG2N(6), .ADDR_W(6), .TW_W(5)) dut_l (
        .clk (clk),
        .rst (rst_l),
        .bus (bl.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic vec_t exp_vec(input int n, input int k);
        vec_t v;
        int   half, b, span;
        half = n / 2;
        v.s  = k / half;
        b    = k % half;
        span = n >> (v.s + 1);
        v.i  = (b / span) * 2 * span + b % span;
        v.j  = v.i + span;
        v.tw = ((b % span) << v.s) % half;
        return v;
    endfunction

    function automatic logic [15:0] twv(input int a);
        return 16'(a * 37 + 5);
    endfunction

    function automatic logic [15:0] img_r(input int k);
        return 16'(k * 1000 + 7);
    endfunction

    function automatic logic [15:0] img_i(input int k);
        return 16'(k * 77 + 300);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- 8-point environment ----------------
    assign bs.bf_done = 1'b1;

    logic [15:0] wr [8];
    logic [15:0] wi [8];
    logic [15:0] rd_r, rd_i, tw_rd, ar, ai, at, f0r, f0i, f1r, f1i;

    // Data RAMs (1-cycle read), twiddle ROM and a simple butterfly
    always @(posedge clk) begin
        if (rst_s) begin
            for (int k = 0; k < 8; k++) begin
                wr[k] <= img_r(k);
                wi[k] <= img_i(k);
            end
        end else begin
            rd_r  <= wr[bs.mem_addr];
            rd_i  <= wi[bs.mem_addr];
            tw_rd <= twv(int'(bs.tw_addr));
            if (bs.a_ld) begin
                ar <= rd_r;
                ai <= rd_i;
                at <= tw_rd;
            end
            if (bs.b_ld) begin
                f0r <= ar + rd_r;
                f0i <= ai + rd_i;
                f1r <= (ar - rd_r) ^ at;
                f1i <= ai - rd_i + at;
            end
            if (bs.mem_we) begin
                wr[bs.mem_addr] <= bs.mem_wsel ? f1r : f0r;
                wi[bs.mem_addr] <= bs.mem_wsel ? f1i : f0i;
            end
        end
    end

    vec_t       cap_s [12];
    int         wa_s [24];
    logic       ws_s [24];
    int         bi_s = 0, wi_s = 0, cap_total_s = 0, done_cnt_s = 0;
    logic [2:0] prev_s = '0;

    // Record (stage, i, j, tw) at each operand-A load and every write
    always @(negedge clk) begin
        prev_s <= bs.mem_addr;
        if (bs.a_ld) begin
            cap_s[bi_s] <= '{int'(bs.stage), int'(prev_s), int'(bs.mem_addr), int'(bs.tw_addr)};
            bi_s        <= (bi_s + 1) % 12;
            cap_total_s <= cap_total_s + 1;
        end
        if (bs.mem_we) begin
            wa_s[wi_s] <= int'(bs.mem_addr);
            ws_s[wi_s] <= bs.mem_wsel;
            wi_s       <= (wi_s + 1) % 24;
        end
        if (bs.done) done_cnt_s <= done_cnt_s + 1;
    end

    // ---------------- 64-point environment ----------------
    int bdc_l = 100;

    // Butterfly completes dly_l cycles after its first WAIT cycle
    always @(posedge clk) begin
        if (bl.bf_start) bdc_l <= 0;
        else if (bdc_l < 100) bdc_l <= bdc_l + 1;
    end
    assign bl.bf_done = (bdc_l >= dly_l);

    vec_t       cap_l [192];
    int         wa_l [384];
    logic       ws_l [384];
    int         wt_l [192];
    int         bi_l = 0, wi_l = 0, wc_l = 0, bad_l = 0, we_total_l = 0, done_cnt_l = 0;
    logic       in_wait_l = 1'b0;
    logic [5:0] prev_l = '0;

    // Record loads, writes and WAIT length; flag strobes seen while waiting
    always @(negedge clk) begin
        prev_l <= bl.mem_addr;
        if (rst_l) begin
            bi_l      <= 0;
            wi_l      <= 0;
            in_wait_l <= 1'b0;
        end else begin
            if (bl.a_ld) begin
                cap_l[bi_l] <= '{int'(bl.stage), int'(prev_l), int'(bl.mem_addr), int'(bl.tw_addr)};
                bi_l        <= (bi_l + 1) % 192;
            end
            if (bl.mem_we) begin
                wa_l[wi_l] <= int'(bl.mem_addr);
                ws_l[wi_l] <= bl.mem_wsel;
                wi_l       <= (wi_l + 1) % 384;
                we_total_l <= we_total_l + 1;
            end
            if (bl.bf_start) begin
                in_wait_l <= 1'b1;
                wc_l      <= 0;
            end else if (in_wait_l) begin
                if (bl.mem_we) begin
                    wt_l[wi_l / 2] <= wc_l;
                    in_wait_l      <= 1'b0;
                end else if (bl.a_ld || bl.b_ld || bl.mem_wsel) begin
                    bad_l <= bad_l + 1;
                end else begin
                    wc_l <= wc_l + 1;
                end
            end
            if (bl.done) done_cnt_l <= done_cnt_l + 1;
        end
    end

    // One full 64-point run; done is expected in the cycle numbered
    // 1 + 192*(6+dly) counting the start cycle as 0 (1154 cycles inclusive at dly=0)
    task automatic run_big(input int dly, input string tag);
        int   n, base_we, base_done, base_bad;
        vec_t v;
        dly_l     = dly;
        base_we   = we_total_l;
        base_done = done_cnt_l;
        base_bad  = bad_l;
        bl.start  = 1'b1;
        tick();
        bl.start  = 1'b0;
        n = 1;
        while (!bl.done && n < 5000) begin
            tick();
            n++;
        end
        check({tag, " done_cycle"}, n, 1 + 192 * (6 + dly));
        tick();
        check({tag, " done_width"}, bl.done, 0);
        check({tag, " busy_after"}, bl.busy, 0);
        check({tag, " we_total"}, we_total_l - base_we, 384);
        check({tag, " done_pulses"}, done_cnt_l - base_done, 1);
        check({tag, " wait_strobes"}, bad_l - base_bad, 0);
        for (int k = 0; k < 192; k++) begin
            v = exp_vec(64, k);
            check($sformatf("%s b%0d stage", tag, k), cap_l[k].s, v.s);
            check($sformatf("%s b%0d i", tag, k), cap_l[k].i, v.i);
            check($sformatf("%s b%0d j", tag, k), cap_l[k].j, v.j);
            check($sformatf("%s b%0d tw", tag, k), cap_l[k].tw, v.tw);
            check($sformatf("%s b%0d waits", tag, k), wt_l[k], 1 + dly);
            check($sformatf("%s w%0d addr", tag, 2 * k), wa_l[2 * k], v.i);
            check($sformatf("%s w%0d addr", tag, 2 * k + 1), wa_l[2 * k + 1], v.j);
            check($sformatf("%s w%0d sel", tag, 2 * k), ws_l[2 * k], 0);
            check($sformatf("%s w%0d sel", tag, 2 * k + 1), ws_l[2 * k + 1], 1);
        end
    endtask

    // ---------------- main sequence ----------------
    vec_t        tbl [12];
    logic [15:0] mr [8];
    logic [15:0] mi [8];

    task automatic apply_model();
        vec_t        v;
        logic [15:0] t, a_r, a_i, b_r, b_i;
        for (int k = 0; k < 12; k++) begin
            v   = exp_vec(8, k);
            t   = twv(v.tw);
            a_r = mr[v.i];
            a_i = mi[v.i];
            b_r = mr[v.j];
            b_i = mi[v.j];
            mr[v.i] = a_r + b_r;
            mi[v.i] = a_i + b_i;
            mr[v.j] = (a_r - b_r) ^ t;
            mi[v.j] = a_i - b_i + t;
        end
    endtask

    task automatic check_small(input string tag, input int base_cap);
        check({tag, " captures"}, cap_total_s - base_cap, 12);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("%s b%0d stage", tag, k), cap_s[k].s, tbl[k].s);
            check($sformatf("%s b%0d i", tag, k), cap_s[k].i, tbl[k].i);
            check($sformatf("%s b%0d j", tag, k), cap_s[k].j, tbl[k].j);
            check($sformatf("%s b%0d tw", tag, k), cap_s[k].tw, tbl[k].tw);
            check($sformatf("%s w%0d", tag, 2 * k), wa_s[2 * k], tbl[k].i);
            check($sformatf("%s w%0d", tag, 2 * k + 1), wa_s[2 * k + 1], tbl[k].j);
            check($sformatf("%s ws%0d", tag, 2 * k + 1), ws_s[2 * k + 1], 1);
        end
        apply_model();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s ram_re%0d", tag, k), wr[k], mr[k]);
            check($sformatf("%s ram_im%0d", tag, k), wi[k], mi[k]);
        end
    endtask

    initial begin
        int   n, base_cap, base_done, idle_bad;
        tbl[0]  = '{0, 0, 4, 0};  tbl[1]  = '{0, 1, 5, 1};
        tbl[2]  = '{0, 2, 6, 2};  tbl[3]  = '{0, 3, 7, 3};
        tbl[4]  = '{1, 0, 2, 0};  tbl[5]  = '{1, 1, 3, 2};
        tbl[6]  = '{1, 4, 6, 0};  tbl[7]  = '{1, 5, 7, 2};
        tbl[8]  = '{2, 0, 1, 0};  tbl[9]  = '{2, 2, 3, 0};
        tbl[10] = '{2, 4, 5, 0};  tbl[11] = '{2, 6, 7, 0};
        for (int k = 0; k < 8; k++) begin
            mr[k] = img_r(k);
            mi[k] = img_i(k);
        end

        rst_s = 1'b1;
        rst_l = 1'b1;
        bs.start = 1'b0;
        bl.start = 1'b0;
        tick();
        tick();
        check("rst_s outputs", {bs.busy, bs.done, bs.mem_we, bs.mem_wsel, bs.a_ld, bs.b_ld,
                                bs.bf_start, bs.mem_addr, bs.tw_addr, bs.stage}, 0);
        check("rst_l busy", bl.busy, 0);
        check("rst_l done", bl.done, 0);
        check("rst_l strobes", {bl.mem_we, bl.mem_wsel, bl.a_ld, bl.b_ld, bl.bf_start}, 0);
        check("rst_l mem_addr", bl.mem_addr, 0);
        check("rst_l tw_addr", bl.tw_addr, 0);
        check("rst_l stage", bl.stage, 0);
        rst_s = 1'b0;
        rst_l = 1'b0;
        tick();

        // 8-point run with start pulses while busy, then start in FIN and IDLE
        base_cap  = cap_total_s;
        base_done = done_cnt_s;
        bs.start  = 1'b1;
        tick();
        bs.start  = 1'b0;
        check("s first busy", bs.busy, 1);
        check("s first addr", bs.mem_addr, 0);
        n = 1;
        while (!bs.done && n < 500) begin
            bs.start = (n == 20 || n == 41);
            tick();
            n++;
        end
        check("s run1 done_cycle", n, 1 + 12 * 6);
        check_small("s run1", base_cap);
        bs.start = 1'b1;
        tick();
        check("s fin start ignored", bs.busy, 0);
        check("s done width", bs.done, 0);
        base_cap = cap_total_s;
        tick();
        bs.start = 1'b0;
        check("s idle start accepted", bs.busy, 1);
        n = 1;
        while (!bs.done && n < 500) begin
            tick();
            n++;
        end
        check("s run2 done_cycle", n, 1 + 12 * 6);
        check_small("s run2", base_cap);
        tick();
        check("s done pulses", done_cnt_s - base_done, 2);

        // 64-point runs: immediate and delayed butterfly completion
        run_big(0, "l dly0");
        run_big(5, "l dly5");

        // Reset while waiting in stage 2, then a fresh full run
        dly_l    = 5;
        bl.start = 1'b1;
        tick();
        bl.start = 1'b0;
        n = 0;
        while (!(bl.bf_start && bl.stage == 6'd2) && n < 3000) begin
            tick();
            n++;
        end
        check("l reach stage2", (n < 3000), 1);
        tick();
        check("l in wait strobes", {bl.mem_we, bl.a_ld, bl.b_ld, bl.bf_start}, 0);
        rst_l = 1'b1;
        tick();
        rst_l = 1'b0;
        check("l abort busy", bl.busy, 0);
        check("l abort we", bl.mem_we, 0);
        check("l abort stage", bl.stage, 0);
        check("l abort done", bl.done, 0);
        idle_bad = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bl.busy || bl.mem_we || bl.done) idle_bad++;
        end
        check("l idle after abort", idle_bad, 0);
        run_big(0, "l restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
